// File: rtl/const_burst_ctrl.sv
// rtl/const_burst_ctrl.sv - constant-value AXI-stream burst generator with settings-bus control
module const_burst_ctrl #(
  parameter int BASE  = 0,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             busy,
  output logic [15:0]      bursts_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [7:0] A_VALUE = 8'(BASE);
  localparam logic [7:0] A_LEN   = 8'(BASE + 1);
  localparam logic [7:0] A_GAP   = 8'(BASE + 2);
  localparam logic [7:0] A_CTRL  = 8'(BASE + 3);

  logic [1:0]       state;
  logic [WIDTH-1:0] value_reg;
  logic [WIDTH-1:0] value_lat;
  logic [15:0]      len_reg;
  logic [15:0]      gap_reg;
  logic [15:0]      len_lat;
  logic [15:0]      gap_lat;
  logic [15:0]      nburst_lat;
  logic [15:0]      beat_cnt;
  logic [15:0]      gap_cnt;
  logic             stop_pend;

  logic        ctrl_wr;
  logic        start_wr;
  logic        stop_wr;
  logic        xfer;
  logic [15:0] done_next;
  logic        end_run;

  // START together with STOP is treated as a plain STOP
  assign ctrl_wr  = set_stb && (set_addr == A_CTRL);
  assign start_wr = ctrl_wr && set_data[0] && !set_data[1];
  assign stop_wr  = ctrl_wr && set_data[1];

  assign o_tvalid = (state == S_BURST);
  assign o_tlast  = o_tvalid && (beat_cnt == len_lat);
  assign o_tdata  = value_lat;
  assign busy     = (state != S_IDLE);
  assign xfer     = o_tvalid && o_tready;

  assign done_next = (bursts_done == 16'hFFFF) ? 16'hFFFF : bursts_done + 16'd1;
  // a STOP arriving on the very tlast cycle still ends the run at this boundary
  assign end_run   = ((nburst_lat != 16'd0) && (done_next == nburst_lat)) || stop_pend || stop_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_reg <= '0;
      len_reg   <= 16'd0;
      gap_reg   <= 16'd0;
    end else if (set_stb) begin
      if (set_addr == A_VALUE) value_reg <= set_data[WIDTH-1:0];
      if (set_addr == A_LEN)   len_reg   <= set_data[15:0];
      if (set_addr == A_GAP)   gap_reg   <= set_data[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      value_lat   <= '0;
      len_lat     <= 16'd0;
      gap_lat     <= 16'd0;
      nburst_lat  <= 16'd0;
      beat_cnt    <= 16'd0;
      gap_cnt     <= 16'd0;
      stop_pend   <= 1'b0;
      bursts_done <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_wr) begin
            value_lat   <= value_reg;
            len_lat     <= (len_reg == 16'd0) ? 16'd1 : len_reg;
            gap_lat     <= gap_reg;
            nburst_lat  <= set_data[31:16];
            bursts_done <= 16'd0;
            beat_cnt    <= 16'd1;
            stop_pend   <= 1'b0;
            state       <= S_BURST;
          end
        end
        S_BURST: begin
          if (stop_wr) stop_pend <= 1'b1;
          if (xfer) begin
            if (o_tlast) begin
              bursts_done <= done_next;
              beat_cnt    <= 16'd1;
              if (end_run) begin
                stop_pend <= 1'b0;
                state     <= S_IDLE;
              end else if (gap_lat != 16'd0) begin
                gap_cnt <= 16'd1;
                state   <= S_GAP;
              end
            end else begin
              beat_cnt <= beat_cnt + 16'd1;
            end
          end
        end
        S_GAP: begin
          if (stop_wr) begin
            stop_pend <= 1'b0;
            state     <= S_IDLE;
          end else if (gap_cnt == gap_lat) begin
            state <= S_BURST;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_const_burst_ctrl.sv
// tb/tb_const_burst_ctrl.sv - self-checking bench for const_burst_ctrl
module tb_const_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        busy;
  logic [15:0] bursts_done;

  const_burst_ctrl #(.BASE(0), .WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
    .o_tready(o_tready), .busy(busy), .bursts_done(bursts_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 0;
  int stall_err = 0;

  logic [31:0] cap_data[$];
  logic        cap_last[$];
  logic        trace[$];
  logic [31:0] exp_data[$];
  logic        exp_last[$];
  logic        exp_trace[$];

  logic        prev_valid = 0, prev_ready = 0, prev_last = 0;
  logic [31:0] prev_data = 0;

  function automatic logic [31:0] ctrl(input int n, input bit start, input bit stop);
    return {n[15:0], 14'd0, stop, start};
  endfunction

  // one clock: inputs change and outputs are observed on the falling edge
  task automatic tick();
    @(negedge clk);
    set_stb  = 1'b0;
    o_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (prev_valid && !prev_ready &&
        (o_tvalid !== 1'b1 || o_tdata !== prev_data || o_tlast !== prev_last))
      stall_err++;
    trace.push_back(o_tvalid);
    if (o_tvalid === 1'b1 && o_tready) begin
      cap_data.push_back(o_tdata);
      cap_last.push_back(o_tlast);
    end
    prev_valid = o_tvalid; prev_ready = o_tready;
    prev_data  = o_tdata;  prev_last  = o_tlast;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    tick();
  endtask

  task automatic clear_cap();
    cap_data.delete(); cap_last.delete(); trace.delete();
    stall_err = 0;
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (busy !== 1'b1) break;
      tick();
    end
  endtask

  task automatic wait_cap(input int n, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (cap_data.size() >= n) break;
      tick();
    end
  endtask

  // reference: n bursts of l beats of v, tlast on every l-th beat
  task automatic build_expect(input logic [31:0] v, input int l, input int n);
    exp_data.delete(); exp_last.delete();
    for (int b = 0; b < n; b++)
      for (int k = 1; k <= l; k++) begin
        exp_data.push_back(v);
        exp_last.push_back(k == l);
      end
  endtask

  // reference valid waveform with tready held high: bursts separated by g idle cycles, then idle
  task automatic build_trace(input int l, input int g, input int n);
    exp_trace.delete();
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < l; k++) exp_trace.push_back(1'b1);
      if (b < n - 1) for (int k = 0; k < g; k++) exp_trace.push_back(1'b0);
    end
    exp_trace.push_back(1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0; o_tready = 1'b1;
    #12;
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", o_tvalid); end
    checks++; if (o_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", o_tlast); end
    checks++; if (o_tdata !== 32'd0) begin errors++; $display("FAIL reset_tdata: got %h want 0", o_tdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bursts_done !== 16'd0) begin errors++; $display("FAIL reset_bursts: got %0d want 0", bursts_done); end
    @(negedge clk); reset_n = 1'b1;
    repeat (3) tick();
    checks++; if (o_tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got valid=%b busy=%b want 0/0", o_tvalid, busy); end
  endtask

  task automatic test_burst_nogap();
    wr(8'd0, 32'h0000A5A5); wr(8'd1, 32'd4); wr(8'd2, 32'd0);
    clear_cap();
    wr(8'd3, ctrl(2, 1, 0));
    checks++; if (o_tvalid !== 1'b1) begin errors++; $display("FAIL s1_latency: got tvalid=%b want 1", o_tvalid); end
    wait_idle(100);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL s1_idle: got busy=%b want 0", busy); end
    checks++; if (bursts_done !== 16'd2) begin errors++; $display("FAIL s1_bursts: got %0d want 2", bursts_done); end
    build_expect(32'h0000A5A5, 4, 2);
    build_trace(4, 0, 2);
    checks++;
    if (cap_data.size() != exp_data.size()) begin errors++; $display("FAIL s1_count: got %0d want %0d", cap_data.size(), exp_data.size()); end
    else foreach (exp_data[i]) begin
      checks++;
      if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin errors++; $display("FAIL s1_beat%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp_data[i], exp_last[i]); end
    end
    checks++;
    if (trace.size() != exp_trace.size()) begin errors++; $display("FAIL s1_trace_len: got %0d want %0d", trace.size(), exp_trace.size()); end
    else foreach (exp_trace[i]) begin
      checks++;
      if (trace[i] !== exp_trace[i]) begin errors++; $display("FAIL s1_trace%0d: got %b want %b", i, trace[i], exp_trace[i]); end
    end
  endtask

  task automatic test_gap_pattern();
    logic [31:0] v;
    v = $urandom;
    wr(8'd0, v); wr(8'd1, 32'd3); wr(8'd2, 32'd2);
    clear_cap();
    wr(8'd3, ctrl(2, 1, 0));
    wait_idle(100);
    build_trace(3, 2, 2);
    build_expect(v, 3, 2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL s2_idle: got busy=%b want 0", busy); end
    checks++;
    if (trace.size() != exp_trace.size()) begin errors++; $display("FAIL s2_trace_len: got %0d want %0d", trace.size(), exp_trace.size()); end
    else foreach (exp_trace[i]) begin
      checks++;
      if (trace[i] !== exp_trace[i]) begin errors++; $display("FAIL s2_trace%0d: got %b want %b", i, trace[i], exp_trace[i]); end
    end
    checks++;
    if (cap_data.size() != exp_data.size()) begin errors++; $display("FAIL s2_count: got %0d want %0d", cap_data.size(), exp_data.size()); end
    else foreach (exp_data[i]) begin
      checks++;
      if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin errors++; $display("FAIL s2_beat%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp_data[i], exp_last[i]); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] v;
    v = $urandom;
    wr(8'd0, v); wr(8'd1, 32'd5); wr(8'd2, $urandom_range(0, 2));
    clear_cap();
    rand_ready = 1;
    wr(8'd3, ctrl(3, 1, 0));
    wait_idle(400);
    rand_ready = 0;
    build_expect(v, 5, 3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL s3_idle: got busy=%b want 0", busy); end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL s3_stable: got %0d unstable stalls want 0", stall_err); end
    checks++; if (bursts_done !== 16'd3) begin errors++; $display("FAIL s3_bursts: got %0d want 3", bursts_done); end
    checks++;
    if (cap_data.size() != exp_data.size()) begin errors++; $display("FAIL s3_count: got %0d want %0d", cap_data.size(), exp_data.size()); end
    else foreach (exp_data[i]) begin
      checks++;
      if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin errors++; $display("FAIL s3_beat%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp_data[i], exp_last[i]); end
    end
  endtask

  task automatic test_stop();
    logic [31:0] v;
    v = $urandom;
    // STOP during beat 3 of an unlimited run: the burst still finishes
    wr(8'd0, v); wr(8'd1, 32'd4); wr(8'd2, 32'd0);
    clear_cap();
    wr(8'd3, ctrl(0, 1, 0));
    wait_cap(3, 50);
    wr(8'd3, ctrl(0, 0, 1));
    wait_idle(50);
    build_expect(v, 4, 1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL s4_idle: got busy=%b want 0", busy); end
    checks++;
    if (cap_data.size() != exp_data.size()) begin errors++; $display("FAIL s4_count: got %0d want %0d", cap_data.size(), exp_data.size()); end
    else foreach (exp_data[i]) begin
      checks++;
      if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin errors++; $display("FAIL s4_beat%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp_data[i], exp_last[i]); end
    end
    // STOP on the tlast cycle itself
    wr(8'd1, 32'd3);
    clear_cap();
    wr(8'd3, ctrl(0, 1, 0));
    wait_cap(3, 50);
    wr(8'd3, ctrl(0, 0, 1));
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_at_last_busy: got %b want 0", busy); end
    checks++; if (cap_data.size() != 3) begin errors++; $display("FAIL stop_at_last_count: got %0d want 3", cap_data.size()); end
    // STOP during GAP
    wr(8'd1, 32'd2); wr(8'd2, 32'd6);
    clear_cap();
    wr(8'd3, ctrl(0, 1, 0));
    for (int i = 0; i < 50; i++) begin
      if (o_tvalid === 1'b0) break;
      tick();
    end
    wr(8'd3, ctrl(0, 0, 1));
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_in_gap_busy: got %b want 0", busy); end
    checks++; if (cap_data.size() != 2) begin errors++; $display("FAIL stop_in_gap_count: got %0d want 2", cap_data.size()); end
    // START with STOP while idle does nothing
    wr(8'd3, ctrl(1, 1, 1));
    tick();
    checks++; if (busy !== 1'b0 || o_tvalid !== 1'b0) begin errors++; $display("FAIL start_stop_idle: got busy=%b valid=%b want 0/0", busy, o_tvalid); end
  endtask

  task automatic test_value_change();
    logic [31:0] v;
    int bad;
    v = $urandom & 32'hFFFF0000;
    wr(8'd0, v); wr(8'd1, 32'd2); wr(8'd2, 32'd0);
    clear_cap();
    wr(8'd3, ctrl(0, 1, 0));
    repeat (6) tick();
    wr(8'd0, 32'h00001234); wr(8'd1, 32'd3);
    wr(8'd3, ctrl(1, 1, 0));
    repeat (10) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL s5_start_busy_ignored: got busy=%b want 1", busy); end
    bad = 0;
    foreach (cap_data[i]) if (cap_data[i] !== v) bad++;
    checks++; if (bad != 0 || cap_data.size() == 0) begin errors++; $display("FAIL s5_old_value: got %0d wrong of %0d want 0 wrong", bad, cap_data.size()); end
    wr(8'd3, ctrl(0, 0, 1));
    wait_idle(20);
    clear_cap();
    wr(8'd3, ctrl(1, 1, 0));
    wait_idle(20);
    build_expect(32'h00001234, 3, 1);
    checks++;
    if (cap_data.size() != exp_data.size()) begin errors++; $display("FAIL s5_count: got %0d want %0d", cap_data.size(), exp_data.size()); end
    else foreach (exp_data[i]) begin
      checks++;
      if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin errors++; $display("FAIL s5_beat%0d: got %h/%b want %h/%b", i, cap_data[i], cap_last[i], exp_data[i], exp_last[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int ones;
    wr(8'd0, $urandom); wr(8'd1, 32'd6);
    wr(8'd3, ctrl(0, 1, 0));
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (o_tvalid !== 1'b0 || o_tlast !== 1'b0) begin errors++; $display("FAIL s6_async: got valid=%b last=%b want 0/0", o_tvalid, o_tlast); end
    checks++; if (busy !== 1'b0 || bursts_done !== 16'd0) begin errors++; $display("FAIL s6_busy: got busy=%b bursts=%0d want 0/0", busy, bursts_done); end
    @(negedge clk); reset_n = 1'b1;
    prev_valid = 1'b0;
    clear_cap();
    repeat (5) tick();
    ones = 0;
    foreach (trace[i]) if (trace[i] !== 1'b0) ones++;
    checks++; if (ones != 0 || busy !== 1'b0) begin errors++; $display("FAIL s6_quiet: got %0d valid cycles busy=%b want 0/0", ones, busy); end
    // registers were cleared: LEN 0 behaves as a single beat of value 0
    clear_cap();
    wr(8'd3, ctrl(1, 1, 0));
    wait_idle(20);
    checks++; if (cap_data.size() != 1) begin errors++; $display("FAIL len0_count: got %0d want 1", cap_data.size()); end
    else begin
      checks++; if (cap_data[0] !== 32'd0 || cap_last[0] !== 1'b1) begin errors++; $display("FAIL len0_beat: got %h/%b want 0/1", cap_data[0], cap_last[0]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    int l, g, n;
    for (int it = 0; it < 6; it++) begin
      v = $urandom; l = $urandom_range(1, 6); g = $urandom_range(0, 3); n = $urandom_range(1, 3);
      wr(8'd0, v); wr(8'd1, l); wr(8'd2, g);
      clear_cap();
      rand_ready = 1'($urandom_range(0, 1));
      wr(8'd3, ctrl(n, 1, 0));
      wait_idle(500);
      build_expect(v, l, n);
      build_trace(l, g, n);
      checks++; if (busy !== 1'b0 || bursts_done !== 16'(n)) begin errors++; $display("FAIL rnd%0d_end: got busy=%b bursts=%0d want 0/%0d", it, busy, bursts_done, n); end
      checks++; if (stall_err != 0) begin errors++; $display("FAIL rnd%0d_stable: got %0d want 0", it, stall_err); end
      checks++;
      if (cap_data.size() != exp_data.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d want %0d", it, cap_data.size(), exp_data.size()); end
      else foreach (exp_data[i]) begin
        checks++;
        if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin errors++; $display("FAIL rnd%0d_beat%0d: got %h/%b want %h/%b", it, i, cap_data[i], cap_last[i], exp_data[i], exp_last[i]); end
      end
      if (!rand_ready) begin
        checks++;
        if (trace.size() != exp_trace.size()) begin errors++; $display("FAIL rnd%0d_trace_len: got %0d want %0d", it, trace.size(), exp_trace.size()); end
        else foreach (exp_trace[i]) begin
          checks++;
          if (trace[i] !== exp_trace[i]) begin errors++; $display("FAIL rnd%0d_trace%0d: got %b want %b", it, i, trace[i], exp_trace[i]); end
        end
      end
      rand_ready = 0;
    end
  endtask

  initial begin
    test_reset();
    test_burst_nogap();
    test_gap_pattern();
    test_stall();
    test_stop();
    test_value_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/const_burst_ctrl.md
CONST_BURST_CTRL -- requirements
Module: const_burst_ctrl

Interface
REQ-001 Parameter BASE, default 0: settings-bus base address; the block decodes BASE+0..BASE+3.
REQ-002 Parameter WIDTH, default 32: o_tdata width, 1..32.
REQ-003 Port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port set_stb, input, 1: settings-bus write strobe.
REQ-006 Port set_addr, input, 8: settings-bus write address.
REQ-007 Port set_data, input, 32: settings-bus write data.
REQ-008 Port o_tdata, output, WIDTH: constant sample value.
REQ-009 Port o_tlast, output, 1: last beat of burst.
REQ-010 Port o_tvalid, output, 1: AXI-stream valid.
REQ-011 Port o_tready, input, 1: AXI-stream ready.
REQ-012 Port busy, output, 1: high when state is not IDLE.
REQ-013 Port bursts_done, output, 16: count of completed bursts since the last start; saturates at 0xFFFF.

Function
REQ-014 Registers, written when set_stb=1 and set_addr matches: BASE+0 VALUE=set_data[WIDTH-1:0]; BASE+1 LEN=set_data[15:0] beats per burst (0 treated as 1); BASE+2 GAP=set_data[15:0] idle cycles between bursts; BASE+3 CTRL: bit0 START, bit1 STOP, bits[31:16] NBURST (0 = unlimited).
REQ-015 Writes to other addresses: ignored; registers hold value.
REQ-016 States: IDLE, BURST, GAP.
REQ-017 IDLE: o_tvalid=0; a CTRL write with START=1 and STOP=0 latches VALUE, LEN, GAP and NBURST, clears bursts_done, and enters BURST on the next edge.
REQ-018 Latency: first o_tvalid=1 is the cycle after the START write cycle.
REQ-019 BURST: o_tvalid=1; o_tdata=latched VALUE; a beat transfers when o_tvalid and o_tready are both 1.
REQ-020 o_tdata, o_tlast and o_tvalid stay stable while o_tvalid=1 and o_tready=0; o_tvalid never drops without a transfer.
REQ-021 Beat counter: counts transfers within a burst; o_tlast=1 exactly on beat LEN (1-based).
REQ-022 On the tlast transfer, bursts_done increments and the burst ends; the next state is chosen by REQ-023 to REQ-025 in priority order.
REQ-023 If NBURST≠0 and bursts_done reaches NBURST, or STOP is pending: next state is IDLE.
REQ-024 Otherwise, if GAP=0: stay in BURST; next beat is beat 1 of the next burst, with no bubble.
REQ-025 Otherwise: enter GAP.
REQ-026 GAP: o_tvalid=0 for exactly GAP cycles, then BURST.
REQ-027 STOP during BURST sets a pending flag; the current burst completes through tlast, then IDLE. A packet is never truncated.
REQ-028 STOP during GAP: IDLE on the next edge.
REQ-029 STOP in IDLE: no effect.
REQ-030 START while busy: ignored.
REQ-031 Writes to VALUE, LEN or GAP while busy: stored in the registers but take effect only at the next START.
REQ-032 A CTRL write with START=1 and STOP=1: treated as STOP only.
REQ-033 When a burst completes and a STOP is written in the same cycle: STOP takes effect at that boundary (next state IDLE).
REQ-034 Counter widths: beat counter and gap counter 16 bits; no wrap is possible because LEN and GAP are at most 0xFFFF.

Reset
REQ-035 reset_n=0 asynchronously forces: state IDLE; o_tvalid=0; o_tlast=0; o_tdata=0; busy=0; bursts_done=0; STOP-pending cleared; VALUE, LEN, GAP and NBURST all 0.
REQ-036 Reset mid-burst abandons the burst immediately; no tlast is emitted.
REQ-037 Release of reset is synchronized to clk; the block stays in IDLE until a START write.

Verification
REQ-038 Scenario 1: VALUE=0xA5A5, LEN=4, GAP=0, NBURST=2, START, o_tready=1 -> 8 beats of 0xA5A5, o_tlast on beats 4 and 8, then IDLE with bursts_done=2.
REQ-039 Scenario 2: LEN=3, GAP=2, NBURST=2 -> pattern V V V(last) 0 0 V V V(last) on o_tvalid, then busy=0.
REQ-040 Scenario 3: LEN=5, o_tready toggled randomly -> o_tdata, o_tlast and o_tvalid stable during stalls; exactly 5 transfers per burst.
REQ-041 Scenario 4: NBURST=0, LEN=4, STOP written after beat 2 -> beats 3 and 4 complete with o_tlast on beat 4, then IDLE.
REQ-042 Scenario 5: VALUE changed to 0x1234 mid-run -> output keeps the old value until STOP, then START; afterwards output is 0x1234.
REQ-043 Scenario 6: reset_n asserted mid-burst -> o_tvalid=0 and busy=0 immediately; after release, no output until START.
